fadd_share_arb: RTL and testbench
=================================

Name: fadd_share_arb

Overview:
- Shares one instance of the team's combinational single-precision adder (sradd, z = a + b, same-sign operands) among NREQ requesters, such as FFT butterfly lanes or accumulators.
- Arbitrates requests round-robin and registers the operands and the result in a 2-stage pipeline with backpressure.
- Returns each sum tagged with the index of the requester that issued it.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of the requester id; must be at least clog2(NREQ).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*32  operand a; requester i owns bits [32i+31:32i].
- req_b  in  NREQ*32  operand b; same packing as req_a.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_z  out  32  sum (IEEE SP bit pattern).
- res_id  out  IDW  requester index of res_z.
- sign_err  out  1  sticky: an accepted pair had a[31] != b[31].
- stat_ops  out  16  count of completed results (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0):
  - s1_v=0, s2_v=0, rr_ptr=0.
  - res_valid=0, res_z=0, res_id=0, req_ready=0, sign_err=0, stat_ops=0.
- Pipeline:
  - S1 holds {a, b, id}. S2 holds {z, id}.
  - The adder reads the S1 registers combinationally. S2 captures the adder output.
  - res_* are driven directly from S2.
- Advance condition: adv2 = ~s2_v | res_ready, and adv1 = ~s1_v | adv2.
- Occupancy states, encoded by {s1_v, s2_v}:
  - EMPTY (00): accepts a request and goes to S1ONLY.
  - S1ONLY (10): S1 moves to S2 on the next edge. With a new grant it goes to BOTH; without one, to S2ONLY.
  - S2ONLY (01): if res_ready and a grant, goes to S1ONLY. If res_ready and no grant, goes to EMPTY. If res_ready=0, it holds, and a grant is still allowed (S1 empty), giving BOTH.
  - BOTH (11): if res_ready, the pipeline shifts and may accept a new grant in the same cycle. If res_ready=0, it stalls: no grant, all registers hold.
- Arbitration:
  - Combinational. When adv1=1, grant the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ.
  - req_ready[i]=1 for the granted i only. A transfer occurs when req_valid[i] & req_ready[i].
  - After a transfer, rr_ptr becomes (i+1) mod NREQ. With no transfer, rr_ptr holds.
  - When adv1=0, req_ready is all zeros.
- Latency and throughput:
  - Accept at edge N means res_valid=1 after edge N+1, with res_ready=1 throughout.
  - Sustained throughput is 1 result per cycle.
- Output stability: while res_valid=1 and res_ready=0, res_z and res_id are held stable.
- Results are produced strictly in grant order; there is no reordering.
- sign_err:
  - Set on the edge that accepts a pair with mismatched signs. The pair is still processed; the adder output is passed through unchanged.
  - Cleared only by reset.
- Reset mid-operation: in-flight S1/S2 contents are discarded immediately, and no result is emitted after reset deasserts.
- Requesters must hold req_valid and their operands stable until granted. Arbiter fairness is guaranteed only under that rule.

Optional Feature:
- Macro: FADD_SHARE_STATS_EN.
- Defined:
  - stat_ops increments on each output handshake (res_valid & res_ready).
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: stat_ops is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Single op: req 0 sends a=32'h3F800000, b=32'h3F800000, res_ready=1 -> res_z=32'h40000000, res_id=0, res_valid exactly 2 edges after req_valid rises.
- Unequal exponents: req 2 sends a=32'h3FC00000 (1.5), b=32'h40200000 (2.5) -> res_z=32'h40800000 (4.0), res_id=2.
- Round-robin: all 4 requesters valid continuously, res_ready=1 -> grant order 0,1,2,3,0,1 and one result per cycle.
- Backpressure: fill both stages, then res_ready=0 for 5 cycles -> req_ready=0 throughout, and res_z/res_id stay constant. Raising res_ready drains the results in order with no loss or duplication.
- Sign mismatch: a=32'hBF800000, b=32'h3F800000 accepted -> sign_err=1 from the next cycle and stays set until rst_n=0.
- Mid-operation reset: assert rst_n=0 with both stages full -> res_valid=0 immediately (async). With FADD_SHARE_STATS_EN, stat_ops=0 and then counts 3 after 3 handshakes.

Source files
------------

// File: rtl/fadd_share_arb.sv
// fadd_share_arb: one combinational same-sign single-precision adder
// (sradd) time-shared by NREQ requesters. A round-robin arbiter feeds
// a two-stage pipeline that has backpressure. S1 holds the operands and
// S2 holds the sum. Each result leaves tagged with the id of the
// requester that issued it.
//
// Optional build macro: FADD_SHARE_STATS_EN. When it is defined,
// stat_ops counts output handshakes and saturates at 16'hFFFF. When it
// is not defined, stat_ops is tied to zero.
//
// Ports:
//   clk, rst_n   clock; asynchronous active-low reset
//   req_valid    per-requester operand valid
//   req_ready    per-requester accept (one-hot or zero)
//   req_a/req_b  operands; requester i owns bits [32i+31:32i]
//   res_valid    result valid (driven from S2)
//   res_ready    downstream accept
//   res_z        sum as an IEEE single-precision bit pattern
//   res_id       index of the requester that issued res_z
//   sign_err     sticky flag: an accepted pair had mismatched sign bits
//   stat_ops     completed-result counter (see macro above)
module fadd_share_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_z,
    output logic [IDW-1:0]     res_id,
    output logic               sign_err,
    output logic [15:0]        stat_ops
);

    // The pipeline occupancy is the pair {s1_v, s2_v}.
    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        S2ONLY = 2'b01,
        S1ONLY = 2'b10,
        BOTH   = 2'b11
    } occ_t;

    occ_t            occ_q, occ_d;
    logic            s1_v, s2_v, adv1, adv2, fire;
    logic [IDW-1:0]  rr_ptr, gnt_id, s1_id, s2_id;
    logic [NREQ-1:0] hi_mask, cand, gnt_oh;
    logic [31:0]     sel_a, sel_b, s1_a, s1_b, s2_z, sum_z;

    // Adder for operands of the same sign. It uses round-to-nearest-even
    // and handles denormal inputs. Inf/NaN on the larger operand passes
    // through. Only the sign of the larger-magnitude operand is used, so a
    // pair with mismatched signs still produces a well-defined pattern.
    function automatic logic [31:0] sradd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b;
        logic [7:0]  ea, eb_eff, d;
        logic [26:0] ma, mb, mb_sh, norm;
        logic [27:0] sum;
        logic [8:0]  e;
        logic [24:0] mant;
        logic        rnd;
        if (x[30:0] >= y[30:0]) begin a = x; b = y; end
        else                    begin a = y; b = x; end
        if (a[30:23] == 8'hFF) return a;
        // Two denormals: the fraction sum carries into the exponent field by itself.
        if (a[30:23] == 8'h00) return {a[31], a[30:0] + b[30:0]};
        ea     = a[30:23];
        eb_eff = (b[30:23] == 8'h00) ? 8'd1 : b[30:23];
        ma     = {1'b1, a[22:0], 3'b000};
        mb     = {(b[30:23] != 8'h00), b[22:0], 3'b000};
        d      = ea - eb_eff;
        // Bits shifted out are kept as a sticky bit in the LSB.
        if (d >= 8'd27) mb_sh = {26'b0, |mb};
        else            mb_sh = (mb >> d) | {26'b0, |(mb & ~(27'h7FF_FFFF << d))};
        sum = {1'b0, ma} + {1'b0, mb_sh};
        e   = {1'b0, ea};
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            e    = e + 9'd1;
        end else begin
            norm = sum[26:0];
        end
        rnd  = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant = {1'b0, norm[26:3]} + {24'b0, rnd};
        if (mant[24]) begin
            mant = {1'b0, mant[24:1]};
            e    = e + 9'd1;
        end
        if (e >= 9'd255) return {a[31], 8'hFF, 23'b0};
        return {a[31], e[7:0], mant[22:0]};
    endfunction

    assign s1_v = occ_q[1];
    assign s2_v = occ_q[0];
    assign adv2 = ~s2_v | res_ready;
    assign adv1 = ~s1_v | adv2;

    // Round-robin: take the lowest valid index at or above rr_ptr. If there
    // is none, wrap around to the lowest valid index overall.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        hi_mask = '0;
        gnt_oh  = '0;
        gnt_id  = '0;
        sel_a   = '0;
        sel_b   = '0;
        for (int i = 0; i < NREQ; i++) hi_mask[i] = (i >= int'(rr_ptr));
        cand = ((req_valid & hi_mask) != '0) ? (req_valid & hi_mask) : req_valid;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh == '0 && cand[i]) begin
                gnt_oh[i] = 1'b1;
                gnt_id    = IDW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_oh[i]) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    // Grants are held off while reset is asserted, so req_ready reads zero then.
    assign req_ready = (adv1 && rst_n) ? gnt_oh : '0;
    assign fire      = |(req_valid & req_ready);

    always_comb begin
        occ_d = occ_q;
        unique case (occ_q)
            EMPTY:   occ_d = fire ? S1ONLY : EMPTY;
            S1ONLY:  occ_d = fire ? BOTH : S2ONLY;
            S2ONLY:  if (res_ready) occ_d = fire ? S1ONLY : EMPTY;
                     else           occ_d = fire ? BOTH : S2ONLY;
            BOTH:    if (res_ready) occ_d = fire ? BOTH : S2ONLY;
                     else           occ_d = BOTH;
            default: occ_d = EMPTY;
        endcase
    end

    assign sum_z = sradd(s1_a, s1_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset as well, because res_z and res_id must read zero out of reset.
            occ_q    <= EMPTY;
            rr_ptr   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
            s2_z     <= '0;
            s2_id    <= '0;
            sign_err <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let S2 capture the old S1 contents on the same edge that S1 reloads.
            occ_q <= occ_d;
            if (fire) begin
                s1_a   <= sel_a;
                s1_b   <= sel_b;
                s1_id  <= gnt_id;
                rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                if (sel_a[31] != sel_b[31]) sign_err <= 1'b1;
            end
            if (adv2 && s1_v) begin
                s2_z  <= sum_z;
                s2_id <= s1_id;
            end
        end
    end

    assign res_valid = s2_v;
    assign res_z     = s2_z;
    assign res_id    = s2_id;

`ifdef FADD_SHARE_STATS_EN
    logic [15:0] stat_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                           stat_q <= '0;
        else if (res_valid && res_ready && stat_q != 16'hFFFF) stat_q <= stat_q + 16'd1;
    end
    assign stat_ops = stat_q;
`else
    assign stat_ops = 16'h0000;
`endif

endmodule

// File: tb/tb_fadd_share_arb.sv
module tb_fadd_share_arb;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid, req_ready;
    logic [NREQ*32-1:0] req_a, req_b;
    logic               res_valid, res_ready;
    logic [31:0]        res_z;
    logic [IDW-1:0]     res_id;
    logic               sign_err;
    logic [15:0]        stat_ops;

    fadd_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_z(res_z), .res_id(res_id),
        .sign_err(sign_err), .stat_ops(stat_ops)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Requester-side intent: each requester holds its valid and operands until it is granted.
    bit          pv[NREQ];
    logic [31:0] pa[NREQ], pb[NREQ];
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pv[i];
            req_a[32*i +: 32]  = pa[i];
            req_b[32*i +: 32]  = pb[i];
        end
    end

    // Reference model. In-flight results form an ordered queue. The head
    // result becomes visible one edge after it is accepted, and a new
    // grant is refused only while two results are in flight and the
    // output is stalled.
    typedef struct {
        logic [31:0]    z;
        logic [IDW-1:0] id;
        bit             known;
        bit             at_out;
    } item_t;
    item_t pipe[$];
    int    m_ptr;
    bit    m_sign;
    int    m_stats;
    int    gi;

    function automatic real to_real(input logic [31:0] x);
        int e = int'(x[30:23]);
        if (e == 0) return real'(x[22:0]) * 2.0 ** (-149);
        return (1.0 + real'(x[22:0]) / 8388608.0) * 2.0 ** (e - 127);
    endfunction

    function automatic logic [31:0] from_real(input real v, input logic s);
        int e = 127;
        int f;
        if (v == 0.0) return {s, 31'b0};
        while (v >= 2.0) begin v = v / 2.0; e++; end
        while (v < 1.0)  begin v = v * 2.0; e--; end
        f = $rtoi((v - 1.0) * 8388608.0);
        return {s, 8'(e), 23'(f)};
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        return from_real(to_real(a) + to_real(b), a[31]);
    endfunction

    // Same-sign operands whose sum is exact in single precision.
    task automatic rand_pair(output logic [31:0] a, output logic [31:0] b);
        logic s  = 1'($urandom_range(0, 1));
        int   ea = int'($urandom_range(110, 140));
        int   eb = ea + int'($urandom_range(0, 6)) - 3;
        a = {s, 8'(ea), 10'($urandom_range(0, 1023)), 13'b0};
        b = {s, 8'(eb), 10'($urandom_range(0, 1023)), 13'b0};
    endtask

    // One clock cycle. It is entered just after a negedge with the inputs
    // already driven. It compares every output against the model, then
    // advances the model across the posedge and returns at the next negedge.
    task automatic cycle();
        int              exp_g;
        logic [NREQ-1:0] exp_ready;
        bit              exp_v, out_hs;
        item_t           it;
        #1;
        exp_v = pipe.size() > 0 && pipe[0].at_out;
        exp_g = -1;
        if (!(pipe.size() == 2 && !res_ready)) begin
            for (int k = 0; k < NREQ; k++) begin
                int j = (m_ptr + k) % NREQ;
                if (pv[j] && exp_g < 0) exp_g = j;
            end
        end
        exp_ready = '0;
        if (exp_g >= 0) exp_ready[exp_g] = 1'b1;
        checks++;
        if (req_ready !== exp_ready) begin
            failures++;
            $display("FAIL req_ready @%0t: got %b expected %b", $time, req_ready, exp_ready);
        end
        checks++;
        if (res_valid !== exp_v) begin
            failures++;
            $display("FAIL res_valid @%0t: got %b expected %b", $time, res_valid, exp_v);
        end
        if (exp_v) begin
            if (pipe[0].known) begin
                checks++;
                if (res_z !== pipe[0].z) begin
                    failures++;
                    $display("FAIL res_z @%0t: got %h expected %h", $time, res_z, pipe[0].z);
                end
            end
            checks++;
            if (res_id !== pipe[0].id) begin
                failures++;
                $display("FAIL res_id @%0t: got %0d expected %0d", $time, res_id, pipe[0].id);
            end
        end
        checks++;
        if (sign_err !== m_sign) begin
            failures++;
            $display("FAIL sign_err @%0t: got %b expected %b", $time, sign_err, m_sign);
        end
        checks++;
        if (stat_ops !== 16'(m_stats)) begin
            failures++;
            $display("FAIL stat_ops @%0t: got %0d expected %0d", $time, stat_ops, m_stats);
        end
        out_hs = exp_v && res_ready;
        @(posedge clk);
        if (out_hs) begin
            void'(pipe.pop_front());
`ifdef FADD_SHARE_STATS_EN
            if (m_stats < 65535) m_stats++;
`endif
        end
        if (pipe.size() > 0 && !pipe[0].at_out) begin
            it = pipe[0];
            it.at_out = 1'b1;
            pipe[0] = it;
        end
        if (exp_g >= 0) begin
            it.z      = ref_add(pa[exp_g], pb[exp_g]);
            it.id     = IDW'(exp_g);
            it.known  = (pa[exp_g][31] == pb[exp_g][31]);
            it.at_out = 1'b0;
            pipe.push_back(it);
            m_ptr = (exp_g + 1) % NREQ;
            if (pa[exp_g][31] != pb[exp_g][31]) m_sign = 1'b1;
        end
        gi = exp_g;
        @(negedge clk);
    endtask

    task automatic clear_model();
        pipe.delete();
        m_ptr   = 0;
        m_sign  = 1'b0;
        m_stats = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_model();
        #1;
        checks++;
        if ({res_valid, res_z, res_id, req_ready, sign_err, stat_ops} !== '0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b z=%h id=%0d ready=%b serr=%b ops=%0d expected all zero",
                     res_valid, res_z, res_id, req_ready, sign_err, stat_ops);
        end
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_op();
        int  edges = 0;
        bit  got = 0;
        pv[0] = 1'b1; pa[0] = 32'h3F800000; pb[0] = 32'h3F800000;
        for (int t = 0; t < 8 && !got; t++) begin
            cycle();
            edges++;
            if (gi == 0) pv[0] = 1'b0;
            if (res_valid === 1'b1) got = 1;
        end
        checks++;
        if (!got || edges != 2) begin
            failures++;
            $display("FAIL single_latency: got %0d edges (seen=%0d) expected 2", edges, got);
        end
        checks++;
        if (res_z !== 32'h40000000 || res_id !== 2'd0) begin
            failures++;
            $display("FAIL single_result: got z=%h id=%0d expected z=40000000 id=0", res_z, res_id);
        end
        cycle();
    endtask

    task automatic test_unequal_exp();
        bit got = 0;
        pv[2] = 1'b1; pa[2] = 32'h3FC00000; pb[2] = 32'h40200000;
        for (int t = 0; t < 8 && !got; t++) begin
            cycle();
            if (gi == 2) pv[2] = 1'b0;
            if (res_valid === 1'b1) got = 1;
        end
        checks++;
        if (!got || res_z !== 32'h40800000 || res_id !== 2'd2) begin
            failures++;
            $display("FAIL unequal_exp: got z=%h id=%0d seen=%0d expected z=40800000 id=2", res_z, res_id, got);
        end
        cycle();
    endtask

    task automatic test_round_robin();
        int order[6] = '{0, 1, 2, 3, 0, 1};
        int results = 0;
        test_reset();
        for (int i = 0; i < NREQ; i++) begin pv[i] = 1'b1; rand_pair(pa[i], pb[i]); end
        res_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            cycle();
            if (t < 6) begin
                checks++;
                if (gi != order[t]) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got %0d expected %0d", t, gi, order[t]);
                end
            end
            if (t >= 1 && res_valid === 1'b1) results++;
            if (gi >= 0) rand_pair(pa[gi], pb[gi]);
        end
        checks++;
        if (results != 9) begin
            failures++;
            $display("FAIL rr_throughput: got %0d results expected 9", results);
        end
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        for (int t = 0; t < 3; t++) cycle();
    endtask

    task automatic test_backpressure();
        logic [31:0]    z0;
        logic [IDW-1:0] id0;
        int             inflight, drained = 0;
        for (int i = 0; i < NREQ; i++) begin pv[i] = 1'b1; rand_pair(pa[i], pb[i]); end
        res_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cycle();
            if (gi >= 0) rand_pair(pa[gi], pb[gi]);
        end
        res_ready = 1'b0;
        #1;
        z0 = res_z;
        id0 = res_id;
        for (int t = 0; t < 5; t++) begin
            cycle();
            checks++;
            if (req_ready !== '0 || res_z !== z0 || res_id !== id0) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got ready=%b z=%h id=%0d expected ready=0 z=%h id=%0d",
                         t, req_ready, res_z, res_id, z0, id0);
            end
        end
        inflight = pipe.size();
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        res_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            #1;
            if (res_valid === 1'b1) drained++;
            cycle();
        end
        checks++;
        if (drained != inflight || inflight != 2) begin
            failures++;
            $display("FAIL drain_count: got %0d drained of %0d expected 2", drained, inflight);
        end
    endtask

    task automatic test_sign_err();
        bit granted = 0;
        pv[1] = 1'b1; pa[1] = 32'hBF800000; pb[1] = 32'h3F800000;
        for (int t = 0; t < 8 && !granted; t++) begin
            cycle();
            if (gi == 1) begin pv[1] = 1'b0; granted = 1; end
        end
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (!granted || sign_err !== 1'b1) begin
                failures++;
                $display("FAIL sign_err_sticky[%0d]: got %b expected 1", t, sign_err);
            end
            cycle();
        end
    endtask

    task automatic test_mid_reset();
        int hs = 0;
        for (int i = 0; i < NREQ; i++) begin pv[i] = 1'b1; rand_pair(pa[i], pb[i]); end
        res_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            cycle();
            if (gi >= 0) rand_pair(pa[gi], pb[gi]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== '0 || stat_ops !== 16'h0 || sign_err !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got valid=%b ready=%b ops=%0d serr=%b expected all zero",
                     res_valid, req_ready, stat_ops, sign_err);
        end
        clear_model();
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) cycle();
        for (int t = 0; t < 20 && hs < 3; t++) begin
            if (!pv[3]) begin pv[3] = 1'b1; rand_pair(pa[3], pb[3]); end
            #1;
            if (res_valid === 1'b1) hs++;
            cycle();
            if (gi == 3) pv[3] = 1'b0;
        end
        pv[3] = 1'b0;
        checks++;
        if (hs != 3 || stat_ops !== 16'(m_stats)) begin
            failures++;
            $display("FAIL stat_after_reset: got ops=%0d handshakes=%0d expected ops=%0d handshakes=3",
                     stat_ops, hs, m_stats);
        end
        for (int t = 0; t < 3; t++) cycle();
    endtask

    task automatic test_random();
        test_reset();
        for (int t = 0; t < 400; t++) begin
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1;
                    rand_pair(pa[i], pb[i]);
                end
            end
            cycle();
            if (gi >= 0) begin
                if ($urandom_range(0, 1) == 0) pv[gi] = 1'b0;
                else rand_pair(pa[gi], pb[gi]);
            end
        end
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        res_ready = 1'b1;
        for (int t = 0; t < 4; t++) cycle();
        checks++;
        if (res_valid !== 1'b0 || pipe.size() != 0) begin
            failures++;
            $display("FAIL random_drain: got valid=%b model_left=%0d expected 0", res_valid, pipe.size());
        end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin pv[i] = 1'b0; pa[i] = '0; pb[i] = '0; end
        res_ready = 1'b1;
        gi = -1;
        test_reset();
        test_single_op();
        test_unequal_exp();
        test_round_robin();
        test_backpressure();
        test_sign_err();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
